// File: rtl/noc_local_ni_pkg.sv
// Shared definitions for the local network interface.
// Flit layout (32 bits): [2:0] dst, [5:3] src, [13:6] seq, [31:14] payload.
// The field positions below are also the ones the router uses for its own
// dst extraction, so both ends agree on one layout.
package noc_local_ni_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DST_LSB     = 0;
    localparam int DST_MSB     = 2;
    localparam int SRC_LSB     = 3;
    localparam int SRC_MSB     = 5;
    localparam int SEQ_LSB     = 6;
    localparam int SEQ_MSB     = 13;
    localparam int PAYLOAD_LSB = 14;
    localparam int PAYLOAD_MSB = 31;

    // The RX buffer does not store dst: every buffered flit is addressed to us.
    localparam int RX_ENTRY_W  = DATA_WIDTH - SRC_LSB;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/ni_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for the NI receive path.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointers only)
//   push_i        write data_i this cycle (accepted when not full, or when
//                 a pop happens in the same cycle)
//   pop_i         remove head entry (ignored when empty)
//   data_i        write data
//   full_o        all DEPTH entries occupied
//   empty_o       no entries
//   data_o        head entry, valid whenever empty_o is low
module ni_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // On a full buffer the write lands in the slot being popped this cycle;
    // the head is still read out from it before the edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/noc_local_ni.sv
// Network interface between a core and the LOCAL port of its mesh router.
// TX: packs {payload, seq, NODE_ADDRESS, dst} into a flit, holds it until
//     the router's LOCAL FIFO is not full, one flit per cycle when streaming.
// RX: filters ejected flits by address, buffers them (FWFT) and presents the
//     head flit to the core on a valid/ready handshake.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   tx_valid/tx_ready             core request handshake
//   tx_dst, tx_payload            request fields
//   net_data_out, net_valid_out   flit and write strobe to the router
//   net_full_in                   router LOCAL FIFO full
//   net_data_in, net_valid_in     flit ejected by the router
//   rx_valid/rx_ready             core receive handshake
//   rx_src, rx_seq, rx_payload    head flit fields (0 when empty)
//   drop_cnt, misroute_cnt        saturating 8-bit error counters
//   seq_err_cnt                   only with NI_SEQ_CHECK_EN: saturating count
//                                 of accepted flits with unexpected seq
// Optional feature macro: NI_SEQ_CHECK_EN.
module noc_local_ni
    import noc_local_ni_pkg::*;
#(
    parameter int unsigned NODE_ADDRESS = 0,
    parameter int          RX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [2:0]  tx_dst,
    input  logic [17:0] tx_payload,
    output logic [31:0] net_data_out,
    output logic        net_valid_out,
    input  logic        net_full_in,
    input  logic [31:0] net_data_in,
    input  logic        net_valid_in,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [2:0]  rx_src,
    output logic [7:0]  rx_seq,
    output logic [17:0] rx_payload,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  misroute_cnt
`ifdef NI_SEQ_CHECK_EN
    ,
    output logic [7:0]  seq_err_cnt
`endif
);

    localparam logic [2:0] NODE_ADDR = NODE_ADDRESS[2:0];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---------------- TX ----------------
    tx_state_e   state_q, state_d;
    logic [31:0] flit_q, flit_d;
    logic [7:0]  tx_seq_q, tx_seq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            flit_q   <= '0;
            tx_seq_q <= '0;
        end else begin
            state_q  <= state_d;
            flit_q   <= flit_d;
            tx_seq_q <= tx_seq_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        flit_d        = flit_q;
        tx_seq_d      = tx_seq_q;
        net_valid_out = (state_q == TX_PEND) && !net_full_in;
        // A flit leaving this cycle frees the register for the next request.
        tx_ready      = (state_q == TX_IDLE) || net_valid_out;
        if (tx_valid && tx_ready) begin
            flit_d   = {tx_payload, tx_seq_q, NODE_ADDR, tx_dst};
            tx_seq_d = tx_seq_q + 8'd1;
            state_d  = TX_PEND;
        end else if (net_valid_out) begin
            state_d  = TX_IDLE;
        end
    end

    assign net_data_out = flit_q;

    // ---------------- RX ----------------
    logic [2:0]            in_dst;
    logic [2:0]            in_src;
    logic [7:0]            in_seq;
    logic                  addr_hit;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [RX_ENTRY_W-1:0] head;
    logic [7:0]            drop_q;
    logic [7:0]            misroute_q;

    assign in_dst    = net_data_in[DST_MSB:DST_LSB];
    assign in_src    = net_data_in[SRC_MSB:SRC_LSB];
    assign in_seq    = net_data_in[SEQ_MSB:SEQ_LSB];
    assign addr_hit  = net_valid_in && (in_dst == NODE_ADDR);
    assign fifo_pop  = !fifo_empty && rx_ready;
    assign fifo_push = addr_hit && (!fifo_full || fifo_pop);

    ni_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (net_data_in[DATA_WIDTH-1:SRC_LSB]),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q     <= '0;
            misroute_q <= '0;
        end else begin
            if (net_valid_in && !addr_hit)
                misroute_q <= sat_inc8(misroute_q);
            if (addr_hit && fifo_full && !fifo_pop)
                drop_q <= sat_inc8(drop_q);
        end
    end

    assign drop_cnt     = drop_q;
    assign misroute_cnt = misroute_q;

    // Head fields are forced to zero while empty so stale storage never shows.
    assign rx_valid   = !fifo_empty;
    assign rx_src     = rx_valid ? head[SRC_MSB-SRC_LSB:0] : '0;
    assign rx_seq     = rx_valid ? head[SEQ_MSB-SRC_LSB:SEQ_LSB-SRC_LSB] : '0;
    assign rx_payload = rx_valid ? head[PAYLOAD_MSB-SRC_LSB:PAYLOAD_LSB-SRC_LSB] : '0;

`ifdef NI_SEQ_CHECK_EN
    logic [7:0] exp_seq_q [8];
    logic [7:0] seq_err_q;

    // Only flits that actually enter the buffer advance the per-source table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) exp_seq_q[i] <= '0;
            seq_err_q <= '0;
        end else if (fifo_push) begin
            if (in_seq != exp_seq_q[in_src])
                seq_err_q <= sat_inc8(seq_err_q);
            exp_seq_q[in_src] <= in_seq + 8'd1;
        end
    end

    assign seq_err_cnt = seq_err_q;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
module tb_noc_local_ni;

    localparam int NA    = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  tx_dst;
    logic [17:0] tx_payload;
    logic [31:0] net_data_out;
    logic        net_valid_out;
    logic        net_full_in;
    logic [31:0] net_data_in;
    logic        net_valid_in;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  rx_src;
    logic [7:0]  rx_seq;
    logic [17:0] rx_payload;
    logic [7:0]  drop_cnt;
    logic [7:0]  misroute_cnt;
`ifdef NI_SEQ_CHECK_EN
    logic [7:0]  seq_err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noc_local_ni #(.NODE_ADDRESS(NA), .RX_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_dst        (tx_dst),
        .tx_payload    (tx_payload),
        .net_data_out  (net_data_out),
        .net_valid_out (net_valid_out),
        .net_full_in   (net_full_in),
        .net_data_in   (net_data_in),
        .net_valid_in  (net_valid_in),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_src        (rx_src),
        .rx_seq        (rx_seq),
        .rx_payload    (rx_payload),
        .drop_cnt      (drop_cnt),
        .misroute_cnt  (misroute_cnt)
`ifdef NI_SEQ_CHECK_EN
        ,
        .seq_err_cnt   (seq_err_cnt)
`endif
    );

    function automatic logic [31:0] mk_flit(input logic [17:0] pl, input logic [7:0] sq,
                                            input logic [2:0] s, input logic [2:0] d);
        return {pl, sq, s, d};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_valid     = 1'b0;
        tx_dst       = '0;
        tx_payload   = '0;
        net_full_in  = 1'b0;
        net_data_in  = '0;
        net_valid_in = 1'b0;
        rx_ready     = 1'b0;
    endtask

    task automatic do_reset(input bit check);
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        if (check) begin
            chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
            chk("rst_net_valid", {31'd0, net_valid_out}, 32'd0);
            chk("rst_net_data", net_data_out, 32'd0);
            chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
            chk("rst_rx_head", {rx_payload, rx_seq, rx_src, 3'd0}, 32'd0);
            chk("rst_counters", {16'd0, drop_cnt, misroute_cnt}, 32'd0);
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic        tv;
        logic [2:0]  dst;
        logic [17:0] pl;
        logic        full;
        logic        e_nv;
        logic        e_rdy;
        logic        chk_d;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[11];

    // Reference-model state for the random phase.
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [7:0]  m_seq;
    int          m_drop;
    int          m_mis;
`ifdef NI_SEQ_CHECK_EN
    logic [7:0]  m_exp[8];
    int          m_serr;
`endif

    initial begin
        logic [31:0] f;
        logic [31:0] prev_f;
        logic        exp_nv;
        logic        exp_rdy;
        logic        pop;
        int          ready_bias;

        vt[0]  = '{1'b1, 3'd5, 18'h2A5A5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0};
        vt[1]  = '{1'b0, 3'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk_flit(18'h2A5A5, 8'd0, 3'd3, 3'd5)};
        vt[2]  = '{1'b0, 3'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk_flit(18'h2A5A5, 8'd0, 3'd3, 3'd5)};
        vt[3]  = '{1'b1, 3'd7, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1, mk_flit(18'h2A5A5, 8'd0, 3'd3, 3'd5)};
        vt[4]  = '{1'b0, 3'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1'b1, mk_flit(18'h2A5A5, 8'd0, 3'd3, 3'd5)};
        vt[5]  = '{1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b1, 1'b1, mk_flit(18'h2A5A5, 8'd0, 3'd3, 3'd5)};
        vt[6]  = '{1'b0, 3'd0, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
        vt[7]  = '{1'b1, 3'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
        vt[8]  = '{1'b1, 3'd3, 18'd2, 1'b0, 1'b1, 1'b1, 1'b1, mk_flit(18'd1, 8'd1, 3'd3, 3'd1)};
        vt[9]  = '{1'b0, 3'd0, 18'd0, 1'b0, 1'b1, 1'b1, 1'b1, mk_flit(18'd2, 8'd2, 3'd3, 3'd3)};
        vt[10] = '{1'b0, 3'd0, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};

        do_reset(1'b1);

        // Single send, back-pressure, then a short two-flit stream.
        for (int i = 0; i < 11; i++) begin
            tx_valid    = vt[i].tv;
            tx_dst      = vt[i].dst;
            tx_payload  = vt[i].pl;
            net_full_in = vt[i].full;
            #1;
            chk($sformatf("vec%0d_net_valid", i), {31'd0, net_valid_out}, {31'd0, vt[i].e_nv});
            chk($sformatf("vec%0d_tx_ready", i), {31'd0, tx_ready}, {31'd0, vt[i].e_rdy});
            if (vt[i].chk_d)
                chk($sformatf("vec%0d_net_data", i), net_data_out, vt[i].e_data);
            cyc();
        end

        // Streaming 300 flits: no bubbles, seq wraps at the 257th flit.
        do_reset(1'b0);
        prev_f = '0;
        for (int k = 0; k <= 300; k++) begin
            tx_valid   = (k < 300);
            tx_dst     = 3'(k);
            tx_payload = 18'(k * 7);
            #1;
            if (k > 0) begin
                chk($sformatf("stream%0d_valid", k), {31'd0, net_valid_out}, 32'd1);
                chk($sformatf("stream%0d_data", k), net_data_out, prev_f);
            end
            prev_f = mk_flit(18'(k * 7), 8'((k) % 256), 3'(NA), 3'(k));
            cyc();
        end
        tx_valid = 1'b0;
        #1;
        chk("stream_end_idle", {31'd0, net_valid_out}, 32'd0);

        // RX overflow: 10 flits into an 8-deep buffer, then drain in order.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            net_valid_in = 1'b1;
            net_data_in  = mk_flit(18'(i + 100), 8'(i), 3'd1, 3'(NA));
            cyc();
        end
        net_valid_in = 1'b0;
        #1;
        chk("ovf_rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            rx_ready = 1'b1;
            #1;
            chk($sformatf("drain%0d_head", i), {rx_payload, rx_seq, rx_src, 3'(NA)},
                mk_flit(18'(i + 100), 8'(i), 3'd1, 3'(NA)));
            cyc();
        end
        rx_ready = 1'b0;
        #1;
        chk("drain_empty", {31'd0, rx_valid}, 32'd0);

        // Misroute leaves the buffer alone.
        net_valid_in = 1'b1;
        net_data_in  = mk_flit(18'h155, 8'd9, 3'd2, 3'(NA + 1));
        cyc();
        net_valid_in = 1'b0;
        #1;
        chk("misroute_cnt", {24'd0, misroute_cnt}, 32'd1);
        chk("misroute_no_rx", {31'd0, rx_valid}, 32'd0);

        // Reset mid-operation with a pending TX flit and buffered RX flits.
        tx_valid    = 1'b1;
        tx_dst      = 3'd6;
        tx_payload  = 18'h1234;
        net_full_in = 1'b1;
        cyc();
        tx_valid     = 1'b0;
        net_valid_in = 1'b1;
        net_data_in  = mk_flit(18'h77, 8'd1, 3'd4, 3'(NA));
        cyc();
        net_valid_in = 1'b0;
        net_full_in  = 1'b0;
        #1;
        chk("pre_rst_net_valid", {31'd0, net_valid_out}, 32'd1);
        chk("pre_rst_rx_valid", {31'd0, rx_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_net_valid", {31'd0, net_valid_out}, 32'd0);
        chk("midrst_net_data", net_data_out, 32'd0);
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_rx_head", {rx_payload, rx_seq, rx_src, 3'd0}, 32'd0);
        chk("midrst_counters", {16'd0, drop_cnt, misroute_cnt}, 32'd0);
        cyc();
        rst = 1'b0;

        // Counter saturation.
        rx_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            net_valid_in = 1'b1;
            net_data_in  = mk_flit(18'(i), 8'(i), 3'd0, 3'(NA + 2));
            cyc();
        end
        rx_ready = 1'b0;
        for (int i = 0; i < 308; i++) begin
            net_data_in = mk_flit(18'(i), 8'(i), 3'd0, 3'(NA));
            cyc();
        end
        net_valid_in = 1'b0;
        #1;
        chk("misroute_sat", {24'd0, misroute_cnt}, 32'd255);
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);

`ifdef NI_SEQ_CHECK_EN
        do_reset(1'b0);
        rx_ready = 1'b1;
        begin
            logic [7:0] sq_list[4];
            logic [7:0] last;
            sq_list = '{8'd0, 8'd1, 8'd3, 8'd4};
            for (int i = 0; i < 4; i++) begin
                net_valid_in = 1'b1;
                net_data_in  = mk_flit(18'd5, sq_list[i], 3'd2, 3'(NA));
                cyc();
            end
            net_valid_in = 1'b0;
            #1;
            chk("seq_err_one", {24'd0, seq_err_cnt}, 32'd1);
            last = 8'd4;
            for (int i = 0; i < 300; i++) begin
                last = last + 8'd2;
                net_valid_in = 1'b1;
                net_data_in  = mk_flit(18'd5, last, 3'd2, 3'(NA));
                cyc();
            end
            net_valid_in = 1'b0;
            #1;
            chk("seq_err_sat", {24'd0, seq_err_cnt}, 32'd255);
        end
`endif

        // Random traffic against the reference model.
        do_reset(1'b0);
        m_seq  = '0;
        m_drop = 0;
        m_mis  = 0;
        txq.delete();
        rxq.delete();
`ifdef NI_SEQ_CHECK_EN
        for (int i = 0; i < 8; i++) m_exp[i] = '0;
        m_serr = 0;
`endif
        for (int c = 0; c < 3000; c++) begin
            ready_bias   = ((c / 200) % 2 == 0) ? 3 : 0;
            tx_valid     = ($urandom_range(0, 3) != 0);
            tx_dst       = 3'($urandom_range(0, 7));
            tx_payload   = 18'($urandom);
            net_full_in  = ($urandom_range(0, 2) == 0);
            net_valid_in = ($urandom_range(0, 1) == 1);
            f            = $urandom;
            if ($urandom_range(0, 4) != 0) f[2:0] = 3'(NA);
            net_data_in  = f;
            rx_ready     = ($urandom_range(0, 3) < ready_bias);
            #1;
            // A pending flit is sent whenever the router is not full; the
            // NI can take a new request when nothing is pending or it leaves.
            exp_nv  = (txq.size() > 0) && !net_full_in;
            exp_rdy = (txq.size() == 0) || exp_nv;
            chk("rnd_net_valid", {31'd0, net_valid_out}, {31'd0, exp_nv});
            chk("rnd_tx_ready", {31'd0, tx_ready}, {31'd0, exp_rdy});
            if (exp_nv) chk("rnd_net_data", net_data_out, txq.pop_front());
            if (tx_valid && exp_rdy) begin
                txq.push_back(mk_flit(tx_payload, m_seq, 3'(NA), tx_dst));
                m_seq = m_seq + 8'd1;
            end
            chk("rnd_rx_valid", {31'd0, rx_valid}, {31'd0, rxq.size() > 0});
            if (rxq.size() > 0)
                chk("rnd_rx_head", {rx_payload, rx_seq, rx_src, 3'(NA)}, rxq[0]);
            chk("rnd_drop", {24'd0, drop_cnt}, 32'(m_drop));
            chk("rnd_mis", {24'd0, misroute_cnt}, 32'(m_mis));
`ifdef NI_SEQ_CHECK_EN
            chk("rnd_seq_err", {24'd0, seq_err_cnt}, 32'(m_serr));
`endif
            pop = (rxq.size() > 0) && rx_ready;
            if (pop) void'(rxq.pop_front());
            if (net_valid_in) begin
                if (f[2:0] != 3'(NA)) begin
                    if (m_mis < 255) m_mis++;
                end else if (rxq.size() == DEPTH) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    rxq.push_back(f);
`ifdef NI_SEQ_CHECK_EN
                    if (f[13:6] != m_exp[f[5:3]] && m_serr < 255) m_serr++;
                    m_exp[f[5:3]] = f[13:6] + 8'd1;
`endif
                end
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Network interface between a processing core and a mesh router's LOCAL port.
- TX path: packs core requests into 32-bit flits and injects them into the router's local input FIFO, respecting the router's full flag.
- RX path: accepts every flit the router ejects (the router never back-pressures LOCAL), filters by address, buffers flits and hands them to the core on a valid/ready handshake.
- One instance per router, same address as its router.

Parameters:
- NODE_ADDRESS, 0, 3-bit mesh address of this node. Must equal the attached router's address.
- RX_DEPTH, 8, receive buffer depth in flits. Power of two, 2..64.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  core offers a request.
- tx_ready  out  1  NI can accept a request this cycle.
- tx_dst  in  3  destination node address.
- tx_payload  in  18  payload.
- net_data_out  out  32  flit to router LOCAL_DATA_IN.
- net_valid_out  out  1  write strobe to router LOCAL_DATA_VALID_IN.
- net_full_in  in  1  router LOCAL_FULL_OUT.
- net_data_in  in  32  flit from router LOCAL_DATA_OUT.
- net_valid_in  in  1  router LOCAL_DATA_VALID_OUT.
- rx_valid  out  1  buffered flit available to core.
- rx_ready  in  1  core consumes the head flit.
- rx_src  out  3  source address of head flit.
- rx_seq  out  8  sequence number of head flit.
- rx_payload  out  18  payload of head flit.
- drop_cnt  out  8  flits dropped because the RX buffer was full; saturates at 255.
- misroute_cnt  out  8  flits received with dst != NODE_ADDRESS; saturates at 255.

Behaviour:
- Flit format: [2:0] dst, [5:3] src, [13:6] seq, [31:14] payload.
- Reset values: net_data_out=0, net_valid_out=0, rx_valid=0, rx_src/rx_seq/rx_payload=0, drop_cnt=0, misroute_cnt=0, tx_seq=0, tx_pend=0, RX buffer empty. tx_ready=1 during and after reset.
- A reset asserted mid-operation discards the pending TX flit and all RX contents immediately; no partial state survives.
- TX state machine, states IDLE / PEND:
  - IDLE, tx_valid=1: register the flit {tx_payload, tx_seq, NODE_ADDRESS, tx_dst} into net_data_out, increment tx_seq, go to PEND.
  - PEND: net_valid_out = ~net_full_in (combinational). The flit is consumed in any cycle where net_valid_out=1.
  - PEND, flit consumed, tx_valid=1: load the next flit in the same cycle and stay in PEND.
  - PEND, flit consumed, tx_valid=0: go to IDLE.
  - PEND, net_full_in=1: hold net_data_out stable; net_valid_out=0.
- tx_ready = IDLE | net_valid_out, giving one flit per cycle when the router is not full.
- Latency: accept at cycle N gives net_valid_out at N+1 at the earliest.
- tx_seq is 8-bit and wraps 255 -> 0.
- tx_dst == NODE_ADDRESS is legal; the router loops the flit back to LOCAL.
- RX path, on each net_valid_in=1:
  - dst != NODE_ADDRESS: increment misroute_cnt and discard the flit.
  - Else, buffer full and no pop this cycle: increment drop_cnt and discard.
  - Otherwise: write the flit to the buffer.
- Simultaneous push and pop on a full buffer succeeds: the pop frees the slot in the same cycle.
- The RX buffer is first-word-fall-through: rx_valid = ~empty, and head fields are driven from the head entry.
- Pop happens when rx_valid & rx_ready. rx_ready while empty is ignored.
- First write into an empty buffer: rx_valid rises the next cycle (1-cycle latency).
- Both counters saturate; they never wrap.

Optional Feature:
- Macro: NI_SEQ_CHECK_EN.
- Defined:
  - Adds an 8-entry table of expected sequence numbers, one per source, reset to 0.
  - Each accepted flit (written to the buffer) with seq != expected[src] increments a saturating 8-bit output seq_err_cnt.
  - expected[src] is then set to seq+1 (mod 256), whether or not a mismatch occurred.
  - Dropped and misrouted flits do not update the table.
- Not defined: no table and no seq_err_cnt port.

Decomposition:
- Flit field positions and widths (DST_LSB/MSB, SRC, SEQ, PAYLOAD) go as defines in the shared global definitions header next to DATA_WIDTH; the router's 3-bit dst extraction uses the same constants.
- One sub-module: ni_rx_fifo.
  - Synchronous FWFT, parameterized depth and width.
  - Ports: push, pop, full, empty, data.
  - Pointers one bit wider than the address to tell full from empty.

Test Plan:
- Single send, NODE_ADDRESS=3: tx_dst=5, tx_payload=0x2A5A5 -> next cycle net_data_out={0x2A5A5,8'd0,3'd3,3'd5}, net_valid_out=1 for 1 cycle; tx_seq becomes 1.
- Back-pressure: net_full_in=1 for 4 cycles while PEND -> net_valid_out=0, net_data_out stable, tx_ready=0; full drops -> flit sent exactly once; 300 sends -> seq wraps to 0 at the 257th flit.
- Streaming: tx_valid held for 10 cycles, net_full_in=0 -> 10 consecutive flits, seq 0..9, no bubbles.
- RX overflow: RX_DEPTH=8, rx_ready=0, 10 valid flits with dst=NODE_ADDRESS -> rx_valid=1, drop_cnt=2; then drain 8 -> order preserved, rx_valid=0.
- Misroute plus reset: flit with dst=NODE_ADDRESS+1 -> misroute_cnt=1, buffer untouched; assert rst mid-stream -> all outputs return to reset values within the same cycle.
- NI_SEQ_CHECK_EN: from src=2, seqs 0,1,3,4 -> seq_err_cnt=1; after 300 gaps -> seq_err_cnt saturates at 255.
